// File: rtl/button_debouncer.sv
// Debounces the four board pushbuttons into clean levels plus one-cycle
// press/release pulses; one synchronizer + counter + FSM lane per button.

module debounce_lane #(
   parameter int DEBOUNCE_CYCLES = 1000000,
   parameter int CNT_WIDTH       = 20
) (
   input  logic clk,
   input  logic reset,
   input  logic raw,
   output logic level,
   output logic press,
   output logic rls
);
   typedef enum logic [1:0] {IDLE, ARM_HIGH, HIGH, ARM_LOW} state_t;

   localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

   state_t               state, state_nxt;
   logic [CNT_WIDTH-1:0] cnt, cnt_nxt;
   logic                 s1, s2;
   logic                 press_nxt, rls_nxt;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         s1    <= 1'b0;
         s2    <= 1'b0;
         state <= IDLE;
         cnt   <= '0;
         level <= 1'b0;
         press <= 1'b0;
         rls   <= 1'b0;
      end else begin
         s1    <= raw;
         s2    <= s1;
         state <= state_nxt;
         cnt   <= cnt_nxt;
         // level is registered from the next state so it moves with the pulse
         level <= (state_nxt == HIGH) || (state_nxt == ARM_LOW);
         press <= press_nxt;
         rls   <= rls_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      press_nxt = 1'b0;
      rls_nxt   = 1'b0;
      case (state)
         IDLE: begin
            if (s2) begin
               state_nxt = ARM_HIGH;
               cnt_nxt   = '0;
            end
         end
         ARM_HIGH: begin
            if (!s2) begin
               state_nxt = IDLE;
               cnt_nxt   = '0;
            end else if (cnt == CNT_LAST) begin
               state_nxt = HIGH;
               press_nxt = 1'b1;
            end else begin
               cnt_nxt = cnt + 1'b1;
            end
         end
         HIGH: begin
            if (!s2) begin
               state_nxt = ARM_LOW;
               cnt_nxt   = '0;
            end
         end
         ARM_LOW: begin
            if (s2) begin
               state_nxt = HIGH;
               cnt_nxt   = '0;
            end else if (cnt == CNT_LAST) begin
               state_nxt = IDLE;
               rls_nxt   = 1'b1;
            end else begin
               cnt_nxt = cnt + 1'b1;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end
endmodule

module button_debouncer #(
   parameter int DEBOUNCE_CYCLES = 1000000,
   parameter int CNT_WIDTH       = 20
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       btnU_raw,
   input  logic       btnL_raw,
   input  logic       btnD_raw,
   input  logic       btnR_raw,
   output logic       btnU,
   output logic       btnL,
   output logic       btnD,
   output logic       btnR,
   output logic [3:0] press,
   output logic [3:0] release_pulse
);
   localparam int NUM_LANES = 4;

   // lane order {U,L,D,R} matches the press/release bit order
   logic [NUM_LANES-1:0] raw_vec;
   logic [NUM_LANES-1:0] lvl_vec;

   assign raw_vec = {btnU_raw, btnL_raw, btnD_raw, btnR_raw};
   assign {btnU, btnL, btnD, btnR} = lvl_vec;

   for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
      debounce_lane #(
         .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
         .CNT_WIDTH      (CNT_WIDTH)
      ) u_lane (
         .clk  (clk),
         .reset(reset),
         .raw  (raw_vec[g]),
         .level(lvl_vec[g]),
         .press(press[g]),
         .rls  (release_pulse[g])
      );
   end
endmodule

// File: tb/tb_button_debouncer.sv
// Directed bench: stimulus queues hand-computed expectations keyed by cycle,
// a negedge monitor pops and compares them against the debouncer outputs.

module tb_button_debouncer;
   logic       clk = 1'b0;
   logic       reset;
   logic       btnU_raw, btnL_raw, btnD_raw, btnR_raw;
   logic       btnU, btnL, btnD, btnR;
   logic [3:0] press, release_pulse;

   typedef struct {
      int         cyc;
      logic [3:0] lvl;
      logic [3:0] pr;
      logic [3:0] rl;
      string      name;
   } exp_t;

   exp_t q[$];
   int   cyc    = 0;
   int   checks = 0;
   int   errors = 0;

   button_debouncer #(.DEBOUNCE_CYCLES(4), .CNT_WIDTH(8)) dut (
      .clk          (clk),
      .reset        (reset),
      .btnU_raw     (btnU_raw),
      .btnL_raw     (btnL_raw),
      .btnD_raw     (btnD_raw),
      .btnR_raw     (btnR_raw),
      .btnU         (btnU),
      .btnL         (btnL),
      .btnD         (btnD),
      .btnR         (btnR),
      .press        (press),
      .release_pulse(release_pulse)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // monitor: compare every expectation due at this cycle
   always @(negedge clk) begin
      exp_t e;
      logic [3:0] lvl;
      lvl = {btnU, btnL, btnD, btnR};
      while (q.size() > 0 && q[0].cyc <= cyc) begin
         e = q.pop_front();
         checks++;
         if (e.cyc != cyc) begin
            errors++;
            $display("FAIL %s: expectation for cycle %0d not sampled (now %0d)", e.name, e.cyc, cyc);
         end else if (lvl !== e.lvl || press !== e.pr || release_pulse !== e.rl) begin
            errors++;
            $display("FAIL %s @%0d: got lvl=%b press=%b rel=%b, want lvl=%b press=%b rel=%b",
                     e.name, cyc, lvl, press, release_pulse, e.lvl, e.pr, e.rl);
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic expect_at(input int c, input logic [3:0] lvl, input logic [3:0] pr,
                            input logic [3:0] rl, input string name);
      exp_t e;
      e.cyc = c; e.lvl = lvl; e.pr = pr; e.rl = rl; e.name = name;
      q.push_back(e);
   endtask

   task automatic wait_until(input int c);
      while (cyc < c) step();
   endtask

   initial begin
      int c;
      reset = 1'b1;
      {btnU_raw, btnL_raw, btnD_raw, btnR_raw} = 4'b0000;
      step();
      expect_at(cyc, 4'b0000, 4'b0000, 4'b0000, "reset_state");
      step();
      step();
      reset = 1'b0;

      // U press: first sampling edge k = c+1, level at k+6
      step();
      btnU_raw = 1'b1; c = cyc;
      expect_at(c + 6,  4'b0000, 4'b0000, 4'b0000, "u_before_rise");
      expect_at(c + 7,  4'b1000, 4'b1000, 4'b0000, "u_rise");
      expect_at(c + 8,  4'b1000, 4'b0000, 4'b0000, "u_pulse_one_cycle");
      expect_at(c + 15, 4'b1000, 4'b0000, 4'b0000, "u_hold");
      wait_until(c + 16);
      btnU_raw = 1'b0; c = cyc;
      expect_at(c + 6, 4'b1000, 4'b0000, 4'b0000, "u_before_fall");
      expect_at(c + 7, 4'b0000, 4'b0000, 4'b1000, "u_fall");
      expect_at(c + 8, 4'b0000, 4'b0000, 4'b0000, "u_after_fall");
      wait_until(c + 9);

      // L high for 3 cycles only: rejected
      btnL_raw = 1'b1; c = cyc;
      for (int i = 1; i <= 10; i++) expect_at(c + i, 4'b0000, 4'b0000, 4'b0000, "l_glitch");
      step(); step(); step();
      btnL_raw = 1'b0;
      wait_until(c + 11);

      // D debounced high, then a 2-cycle low bounce, then a real release
      btnD_raw = 1'b1; c = cyc;
      expect_at(c + 7, 4'b0010, 4'b0010, 4'b0000, "d_rise");
      wait_until(c + 9);
      btnD_raw = 1'b0; c = cyc;
      for (int i = 1; i <= 10; i++) expect_at(c + i, 4'b0010, 4'b0000, 4'b0000, "d_bounce");
      step(); step();
      btnD_raw = 1'b1;
      wait_until(c + 11);
      btnD_raw = 1'b0; c = cyc;
      expect_at(c + 6, 4'b0010, 4'b0000, 4'b0000, "d_before_fall");
      expect_at(c + 7, 4'b0000, 4'b0000, 4'b0010, "d_fall");
      expect_at(c + 8, 4'b0000, 4'b0000, 4'b0000, "d_after_fall");
      wait_until(c + 9);

      // U and R together
      btnU_raw = 1'b1; btnR_raw = 1'b1; c = cyc;
      expect_at(c + 6, 4'b0000, 4'b0000, 4'b0000, "ur_before_rise");
      expect_at(c + 7, 4'b1001, 4'b1001, 4'b0000, "ur_rise");
      expect_at(c + 8, 4'b1001, 4'b0000, 4'b0000, "ur_hold");
      wait_until(c + 9);
      btnU_raw = 1'b0; btnR_raw = 1'b0; c = cyc;
      expect_at(c + 7, 4'b0000, 4'b0000, 4'b1001, "ur_fall");
      expect_at(c + 8, 4'b0000, 4'b0000, 4'b0000, "ur_after_fall");
      wait_until(c + 9);

      // R: reset at count 2 aborts the count, full count needed afterwards
      btnR_raw = 1'b1; c = cyc;
      wait_until(c + 5);
      reset = 1'b1;
      expect_at(c + 5, 4'b0000, 4'b0000, 4'b0000, "r_reset_mid");
      step(); step();
      reset = 1'b0;
      expect_at(c + 13, 4'b0000, 4'b0000, 4'b0000, "r_before_rise");
      expect_at(c + 14, 4'b0001, 4'b0001, 4'b0000, "r_rise_after_reset");
      expect_at(c + 15, 4'b0001, 4'b0000, 4'b0000, "r_hold");
      wait_until(c + 16);

      // all four high, then reset: outputs clear with no clock edge, no release
      btnU_raw = 1'b1; btnL_raw = 1'b1; btnD_raw = 1'b1; c = cyc;
      expect_at(c + 7, 4'b1111, 4'b1110, 4'b0000, "all_rise");
      expect_at(c + 8, 4'b1111, 4'b0000, 4'b0000, "all_hold");
      wait_until(c + 9);
      reset = 1'b1; c = cyc;
      expect_at(c, 4'b0000, 4'b0000, 4'b0000, "all_async_reset");
      step();
      {btnU_raw, btnL_raw, btnD_raw, btnR_raw} = 4'b0000;
      step();
      reset = 1'b0;
      for (int i = 3; i <= 10; i++) expect_at(c + i, 4'b0000, 4'b0000, 4'b0000, "no_release_after_reset");

      for (int i = 0; i < 200 && q.size() > 0; i++) step();
      if (q.size() > 0) begin
         errors += q.size();
         checks += q.size();
         $display("FAIL drain: %0d expectations never checked, want 0", q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
